// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one two-function ALU between two requesters
module alu_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int ALU_LAT = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  input  logic             req1_valid,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             alu_op_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);
  localparam int WC_W = ALU_LAT > 0 ? $clog2(ALU_LAT + 1) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [WC_W-1:0] wait_cnt;
  logic last_grant, grant, gid, accept;
  always_comb begin
    grant = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    req0_ready = (state == IDLE) & req0_valid & ~grant;
    req1_ready = (state == IDLE) & req1_valid & grant;
    accept = req0_ready | req1_ready;
    state_nxt = (state == IDLE) ? (accept ? WAIT : IDLE) :
                (state == WAIT) ? (wait_cnt == '0 ? RESP : WAIT) : IDLE;
    busy = state != IDLE;
    rsp0_valid = (state == RESP) & ~gid;
    rsp1_valid = (state == RESP) & gid;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      gid <= 1'b0;
      wait_cnt <= '0;
      alu_op_sel <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      rsp0_data <= '0;
      rsp1_data <= '0;
      ops_done <= '0;
    end else begin
      if (accept) begin
        alu_op_sel <= grant ? req1_op : req0_op;
        alu_a <= grant ? req1_a : req0_a;
        alu_b <= grant ? req1_b : req0_b;
        gid <= grant;
        last_grant <= grant;
        wait_cnt <= WC_W'(ALU_LAT);
      end
      if (state == WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - WC_W'(1);
      // result is sampled the cycle the countdown has expired, so ALU_LAT=0 reads a combinational ALU directly
      if (state == WAIT && wait_cnt == '0 && !gid) rsp0_data <= alu_result;
      if (state == WAIT && wait_cnt == '0 && gid) rsp1_data <= alu_result;
      if (state == RESP) ops_done <= ops_done + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed scenarios plus a randomized run against a timing/scoreboard model
module tb_alu_rr_arbiter;
  localparam int W = 32;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_op, req0_ready, rsp0_valid;
  logic [W-1:0] req0_a, req0_b, rsp0_data;
  logic req1_valid, req1_op, req1_ready, rsp1_valid;
  logic [W-1:0] req1_a, req1_b, rsp1_data;
  logic alu_op_sel, busy;
  logic [W-1:0] alu_a, alu_b;
  logic [W-1:0] alu_result = '0;
  logic [CW-1:0] ops_done;
  int n_cmp = 0;
  int n_err = 0;
  int exp_ops = 0;

  always #5 clk = ~clk;
  always @(posedge clk) alu_result <= alu_op_sel ? (alu_a & alu_b) : (alu_a + alu_b);

  alu_rr_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .alu_op_sel(alu_op_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .busy(busy), .ops_done(ops_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    tick();
    tick();
    rst = 1'b0;
    exp_ops = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (ops_done !== '0) begin n_err++; $display("FAIL reset_ops: got %0d want 0", ops_done); end
    n_cmp++; if ({alu_op_sel, alu_a, alu_b} !== '0) begin n_err++; $display("FAIL reset_alu: got %0b %h %h want 0", alu_op_sel, alu_a, alu_b); end
    n_cmp++; if ({rsp0_valid, rsp1_valid, rsp0_data, rsp1_data} !== '0) begin n_err++; $display("FAIL reset_rsp: got %0b%0b %h %h want 0", rsp0_valid, rsp1_valid, rsp0_data, rsp1_data); end
  endtask

  task automatic test_single0();
    req0_valid = 1; req0_op = 0; req0_a = 15; req0_b = 17;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL s0_ready: got %0b want 1", req0_ready); end
    tick();
    req0_valid = 0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (rsp0_valid !== (k == 2)) begin n_err++; $display("FAIL s0_rsp0_valid k=%0d: got %0b want %0b", k, rsp0_valid, k == 2); end
      n_cmp++; if (rsp1_valid !== 1'b0) begin n_err++; $display("FAIL s0_rsp1_valid k=%0d: got %0b want 0", k, rsp1_valid); end
      if (k == 2) begin
        n_cmp++; if (rsp0_data !== 32'd32) begin n_err++; $display("FAIL s0_data: got %0d want 32", rsp0_data); end
      end
      tick();
    end
    exp_ops++;
    n_cmp++; if (ops_done !== CW'(exp_ops)) begin n_err++; $display("FAIL s0_ops: got %0d want %0d", ops_done, exp_ops); end
  endtask

  task automatic test_single1();
    req1_valid = 1; req1_op = 1; req1_a = 15; req1_b = 17;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL s1_ready: got %0b%0b want 01", req0_ready, req1_ready); end
    tick();
    req1_valid = 0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if ({req0_ready, rsp0_valid, rsp1_valid} !== {2'b00, k == 2}) begin n_err++; $display("FAIL s1_flags k=%0d: got %0b%0b%0b want 00%0b", k, req0_ready, rsp0_valid, rsp1_valid, k == 2); end
      if (k == 2) begin
        n_cmp++; if (rsp1_data !== 32'd1) begin n_err++; $display("FAIL s1_data: got %0d want 1", rsp1_data); end
        n_cmp++; if (rsp0_data !== 32'd32) begin n_err++; $display("FAIL s1_rsp0_held: got %0d want 32", rsp0_data); end
      end
      tick();
    end
    exp_ops++;
    n_cmp++; if (ops_done !== CW'(exp_ops)) begin n_err++; $display("FAIL s1_ops: got %0d want %0d", ops_done, exp_ops); end
  endtask

  task automatic test_tie();
    do_reset();
    req0_valid = 1; req0_op = 0; req0_a = 32'hFFFF_FFFF; req0_b = 1;
    req1_valid = 1; req1_op = 1; req1_a = 32'hFFFF_FFFF; req1_b = 0;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL tie_first: got %0b%0b want 10", req0_ready, req1_ready); end
    tick();
    req0_valid = 0;
    tick(); tick();
    n_cmp++; if ({rsp0_valid, rsp1_valid, req1_ready} !== 3'b100) begin n_err++; $display("FAIL tie_rsp0: got %0b%0b%0b want 100", rsp0_valid, rsp1_valid, req1_ready); end
    n_cmp++; if (rsp0_data !== 32'd0) begin n_err++; $display("FAIL tie_data0: got %h want 0", rsp0_data); end
    tick();
    n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL tie_second: got %0b want 1", req1_ready); end
    tick();
    req1_valid = 0;
    n_cmp++; if ({alu_op_sel, alu_a, alu_b} !== {1'b1, 32'hFFFF_FFFF, 32'h0}) begin n_err++; $display("FAIL tie_alu: got %0b %h %h want 1 ffffffff 0", alu_op_sel, alu_a, alu_b); end
    tick(); tick();
    n_cmp++; if ({rsp0_valid, rsp1_valid} !== 2'b01) begin n_err++; $display("FAIL tie_rsp1: got %0b%0b want 01", rsp0_valid, rsp1_valid); end
    n_cmp++; if (rsp1_data !== 32'd0) begin n_err++; $display("FAIL tie_data1: got %h want 0", rsp1_data); end
    tick();
    exp_ops = 2;
    n_cmp++; if (ops_done !== CW'(exp_ops)) begin n_err++; $display("FAIL tie_ops: got %0d want %0d", ops_done, exp_ops); end
  endtask

  task automatic test_rr();
    int ids[$];
    int cyc[$];
    req0_valid = 1; req0_op = 0; req0_a = $urandom; req0_b = $urandom;
    req1_valid = 1; req1_op = 1; req1_a = $urandom; req1_b = $urandom;
    #1;
    for (int c = 0; c < 16; c++) begin
      n_cmp++; if (req0_ready && req1_ready) begin n_err++; $display("FAIL rr_both_ready c=%0d: got 11 want at most one", c); end
      if (req0_ready) begin ids.push_back(0); cyc.push_back(c); end
      if (req1_ready) begin ids.push_back(1); cyc.push_back(c); end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    n_cmp++; if (ids.size() !== 4) begin n_err++; $display("FAIL rr_count: got %0d want 4", ids.size()); end
    for (int i = 0; i < ids.size() && i < 4; i++) begin
      n_cmp++; if (ids[i] !== i % 2) begin n_err++; $display("FAIL rr_order i=%0d: got %0d want %0d", i, ids[i], i % 2); end
      if (i > 0) begin
        n_cmp++; if (cyc[i] - cyc[i-1] !== 4) begin n_err++; $display("FAIL rr_gap i=%0d: got %0d want 4", i, cyc[i] - cyc[i-1]); end
      end
    end
    exp_ops += 4;
    n_cmp++; if (ops_done !== CW'(exp_ops)) begin n_err++; $display("FAIL rr_ops: got %0d want %0d", ops_done, exp_ops); end
  endtask

  task automatic test_reset_mid();
    req0_valid = 1; req0_op = 0; req0_a = $urandom | 1; req0_b = $urandom | 1;
    #1;
    tick();
    req0_valid = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ops = 0;
    n_cmp++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin n_err++; $display("FAIL rm_flags: got %0b%0b%0b want 000", busy, rsp0_valid, rsp1_valid); end
    n_cmp++; if (ops_done !== '0) begin n_err++; $display("FAIL rm_ops: got %0d want 0", ops_done); end
    n_cmp++; if ({alu_a, alu_b} !== '0) begin n_err++; $display("FAIL rm_alu: got %h %h want 0 0", alu_a, alu_b); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin n_err++; $display("FAIL rm_quiet k=%0d: got %0b%0b%0b want 000", k, busy, rsp0_valid, rsp1_valid); end
    end
  endtask

  task automatic test_hold();
    do_reset();
    req0_valid = 1; req0_op = 1; req0_a = $urandom; req0_b = $urandom;
    req1_valid = 1; req1_op = 0; req1_a = $urandom; req1_b = $urandom;
    #1;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if ({busy, req0_ready, req1_ready} !== 3'b100) begin n_err++; $display("FAIL hold k=%0d: got %0b%0b%0b want 100", k, busy, req0_ready, req1_ready); end
      tick();
    end
    n_cmp++; if ({busy, req0_ready, req1_ready} !== 3'b001) begin n_err++; $display("FAIL hold_idle: got %0b%0b%0b want 001", busy, req0_ready, req1_ready); end
    req0_valid = 0; req1_valid = 0;
    exp_ops = 1;
    n_cmp++; if (ops_done !== CW'(exp_ops)) begin n_err++; $display("FAIL hold_ops: got %0d want %0d", ops_done, exp_ops); end
  endtask

  task automatic test_random();
    int free_edges = 0;
    int last = 1;
    int gid = 0;
    int g;
    logic [W-1:0] val = '0;
    logic [W-1:0] data [2] = '{default: '0};
    logic [W-1:0] ea = '0, eb = '0;
    logic eop = 0;
    logic acc;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req0_valid = $urandom_range(0, 99) < 60; req0_op = $urandom_range(0, 1);
      req1_valid = $urandom_range(0, 99) < 60; req1_op = $urandom_range(0, 1);
      req0_a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom; req0_b = $urandom;
      req1_a = $urandom; req1_b = ($urandom_range(0, 7) == 0) ? 32'h1 : $urandom;
      #1;
      acc = free_edges == 0 && (req0_valid || req1_valid);
      g = (req0_valid && req1_valid) ? 1 - last : (req1_valid ? 1 : 0);
      n_cmp++; if ({req0_ready, req1_ready} !== {acc && g == 0, acc && g == 1}) begin n_err++; $display("FAIL rnd_ready c=%0d: got %0b%0b want %0b%0b", c, req0_ready, req1_ready, acc && g == 0, acc && g == 1); end
      tick();
      if (acc) begin
        last = g; gid = g; free_edges = 3;
        eop = g ? req1_op : req0_op;
        ea = g ? req1_a : req0_a;
        eb = g ? req1_b : req0_b;
        val = eop ? (ea & eb) : (ea + eb);
      end else if (free_edges > 0) begin
        if (free_edges == 2) data[gid] = val;
        if (free_edges == 1) exp_ops++;
        free_edges--;
      end
      n_cmp++; if (busy !== (free_edges > 0)) begin n_err++; $display("FAIL rnd_busy c=%0d: got %0b want %0b", c, busy, free_edges > 0); end
      n_cmp++; if ({rsp0_valid, rsp1_valid} !== {free_edges == 1 && gid == 0, free_edges == 1 && gid == 1}) begin n_err++; $display("FAIL rnd_rsp_valid c=%0d: got %0b%0b want %0b%0b", c, rsp0_valid, rsp1_valid, free_edges == 1 && gid == 0, free_edges == 1 && gid == 1); end
      n_cmp++; if ({rsp0_data, rsp1_data} !== {data[0], data[1]}) begin n_err++; $display("FAIL rnd_rsp_data c=%0d: got %h %h want %h %h", c, rsp0_data, rsp1_data, data[0], data[1]); end
      n_cmp++; if ({alu_op_sel, alu_a, alu_b} !== {eop, ea, eb}) begin n_err++; $display("FAIL rnd_alu c=%0d: got %0b %h %h want %0b %h %h", c, alu_op_sel, alu_a, alu_b, eop, ea, eb); end
      n_cmp++; if (ops_done !== CW'(exp_ops)) begin n_err++; $display("FAIL rnd_ops c=%0d: got %0d want %0d", c, ops_done, exp_ops); end
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_op = 0; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_op = 0; req1_a = '0; req1_b = '0;
    test_reset();
    test_single0();
    test_single1();
    test_tie();
    test_rr();
    test_reset_mid();
    test_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
